// File: rtl/serial_bus_arbiter_if.sv
// ============================================================================
// serial_bus_arbiter_if : request/grant and bus-activity bundle for the arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

interface serial_bus_arbiter_if #(
  parameter int NUM_MASTERS = 2
);
  localparam int ID_W = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] req;
  logic                   master_valid;
  logic                   slave_ready;
  logic                   slave_valid;
  logic [NUM_MASTERS-1:0] grant;
  logic [ID_W-1:0]        grant_id;
  logic                   bus_busy;
  logic                   timeout;

  // Requesting side: masters plus the observed bus handshake lines
  modport master (
    output req, master_valid, slave_ready, slave_valid,
    input  grant, grant_id, bus_busy, timeout
  );

  // Arbiter side
  modport slave (
    input  req, master_valid, slave_ready, slave_valid,
    output grant, grant_id, bus_busy, timeout
  );
endinterface

`default_nettype wire

// File: rtl/serial_bus_arbiter.sv
// ============================================================================
// serial_bus_arbiter : round-robin owner arbitration for the bit-serial bus,
// one-cycle turnaround; stall revocation when ARB_TIMEOUT_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT     = 64
) (
  input  wire logic           clk,
  input  wire logic           rstn,
  serial_bus_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                 state, state_n;
  logic [NUM_MASTERS-1:0] grant_q, grant_n;
  logic [ID_W-1:0]        id_q, id_n;
  logic [ID_W-1:0]        last_q, last_n;
  logic                   timeout_q, timeout_n;
  logic [NUM_MASTERS-1:0] eligible;
  logic                   expire;
  logic                   hit;
  logic [ID_W-1:0]        winner;
  logic [ID_W-1:0]        cand;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0]       idle_cnt, idle_cnt_n;
  logic [NUM_MASTERS-1:0] mask, mask_n;
  logic                   bus_idle;

  assign bus_idle = !(bus.master_valid || bus.slave_ready || bus.slave_valid);
  // Only a still-requesting owner can be revoked; a dropped req releases normally
  assign expire   = (state == GRANT) && bus.req[id_q] && bus_idle &&
                    (idle_cnt == CNT_W'(TIMEOUT - 1));
  assign eligible = bus.req & ~mask;

  always_comb begin
    mask_n = mask & bus.req;
    if (expire) begin
      mask_n[id_q] = 1'b1;
    end
    idle_cnt_n = '0;
    if ((state == GRANT) && (state_n == GRANT) && bus_idle) begin
      idle_cnt_n = idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idle_cnt <= '0;
      mask     <= '0;
    end else begin
      idle_cnt <= idle_cnt_n;
      mask     <= mask_n;
    end
  end
`else
  logic unused_activity;

  assign unused_activity = bus.master_valid ^ bus.slave_ready ^ bus.slave_valid ^
                           (TIMEOUT > 1);
  assign expire          = 1'b0;
  assign eligible        = bus.req;
`endif

  // Rotating search starting just after the previous owner
  always_comb begin
    hit    = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = ID_W'((int'(last_q) + k) % NUM_MASTERS);
      if (!hit && eligible[cand]) begin
        hit    = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_n   = state;
    grant_n   = grant_q;
    id_n      = id_q;
    last_n    = last_q;
    timeout_n = 1'b0;
    case (state)
      IDLE, RELEASE: begin
        grant_n = '0;
        state_n = IDLE;
        if (hit) begin
          state_n = GRANT;
          grant_n = NUM_MASTERS'(1) << winner;
          id_n    = winner;
          last_n  = winner;
        end
      end
      GRANT: begin
        if (!bus.req[id_q] || expire) begin
          state_n   = RELEASE;
          grant_n   = '0;
          timeout_n = expire;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      grant_q   <= '0;
      id_q      <= '0;
      last_q    <= ID_W'(NUM_MASTERS - 1);
      timeout_q <= 1'b0;
    end else begin
      state     <= state_n;
      grant_q   <= grant_n;
      id_q      <= id_n;
      last_q    <= last_n;
      timeout_q <= timeout_n;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.grant_id = id_q;
  assign bus.bus_busy = |grant_q;
  assign bus.timeout  = timeout_q;

endmodule

`default_nettype wire
